reg_share_arbiter: RTL and testbench

- Round-robin write arbiter and sequencer for a shared W-bit enable/set register (posedge clock, clock enable, set-to-all-ones).
- Up to NREQ requesters compete for write access. The block sequences each winner's data onto the register's D/enable inputs and returns a completion acknowledge.
- A separate set request drives the register's set input through the same sequencer.
- Sits between requesting control blocks and the shared register.

---
 rtl/reg_share_arbiter.sv | 151 +++++++++++++++
 tb/tb_reg_share_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_share_arbiter.sv
// Round-robin write arbiter and sequencer for a shared W-bit enable/set register.
// Optional per-requester grant statistics are built when ARB_STATS_EN is defined.
module reg_share_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] wdata,
    input  logic              set_req,
    output logic [NREQ-1:0]   gnt,
    output logic              ack,
    output logic              set_ack,
    output logic [W-1:0]      reg_d,
    output logic              reg_en,
    output logic              reg_set,
    output logic              busy,
    input  logic [2:0]        stat_sel,
    output logic [7:0]        stat_cnt
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StDone,
        StSet,
        StSetDone
    } state_e;

    state_e        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [PW-1:0] pick;
    logic          found;
    logic [W-1:0]  pick_data;
    logic [PW:0]   scan;

    // Round-robin search: ptr, ptr+1, ... with wrap; first asserted req wins.
    always_comb begin
        pick      = '0;
        found     = 1'b0;
        pick_data = '0;
        scan      = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan = {1'b0, ptr} + (PW + 1)'(i);
            if (scan >= (PW + 1)'(NREQ)) begin
                scan = scan - (PW + 1)'(NREQ);
            end
            if (!found && req[scan[PW-1:0]]) begin
                found = 1'b1;
                pick  = scan[PW-1:0];
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (pick == PW'(j)) begin
                pick_data = wdata[j*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StIdle;
            ptr     <= '0;
            win     <= '0;
            gnt     <= '0;
            ack     <= 1'b0;
            set_ack <= 1'b0;
            reg_d   <= '0;
            reg_en  <= 1'b0;
            reg_set <= 1'b0;
            busy    <= 1'b0;
        end else begin
            ack     <= 1'b0;
            set_ack <= 1'b0;
            reg_en  <= 1'b0;
            reg_set <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (set_req) begin
                        state   <= StSet;
                        reg_set <= 1'b1;
                        busy    <= 1'b1;
                    end else if (found) begin
                        state  <= StGrant;
                        win    <= pick;
                        gnt    <= {{(NREQ - 1){1'b0}}, 1'b1} << pick;
                        reg_d  <= pick_data;
                        reg_en <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                StGrant: begin
                    state <= StDone;
                    ptr   <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
                    ack   <= 1'b1;
                end
                StDone: begin
                    state <= StIdle;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
                StSet: begin
                    state   <= StSetDone;
                    set_ack <= 1'b1;
                end
                StSetDone: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic [7:0] cnt [NREQ];

    // Saturating grant counters, bumped once per GRANT cycle of the owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt[i] <= '0;
            end
        end else if (state == StGrant && cnt[win] != 8'hFF) begin
            cnt[win] <= cnt[win] + 8'd1;
        end
    end

    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (stat_sel == 3'(i)) begin
                stat_cnt = cnt[i];
            end
        end
    end
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed self-checking bench for reg_share_arbiter (NREQ=4, W=4).
// Grant statistics are checked against saturating values when ARB_STATS_EN is defined.
module tb_reg_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] wdata = 16'h7A5C;
    logic        set_req = 1'b0;
    logic [3:0]  gnt;
    logic        ack;
    logic        set_ack;
    logic [3:0]  reg_d;
    logic        reg_en;
    logic        reg_set;
    logic        busy;
    logic [2:0]  stat_sel = 3'd3;
    logic [7:0]  stat_cnt;

    int  total = 0;
    int  bad = 0;
    time ack_t = 0;
    time t0 = 0;

    reg_share_arbiter #(.NREQ(4), .W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .wdata    (wdata),
        .set_req  (set_req),
        .gnt      (gnt),
        .ack      (ack),
        .set_ack  (set_ack),
        .reg_d    (reg_d),
        .reg_en   (reg_en),
        .reg_set  (reg_set),
        .busy     (busy),
        .stat_sel (stat_sel),
        .stat_cnt (stat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a grant, checks the GRANT and DONE cycles, drops the
    // requester's req once ack is seen, and checks that ack lasts one cycle.
    task automatic expect_write(input string tag, input logic [3:0] egnt, input logic [3:0] ed,
                                input logic [3:0] drop);
        int n;
        @(negedge clk);
        n = 1;
        while (gnt === 4'b0000 && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".gnt"}, 32'(gnt), 32'(egnt));
        chk({tag, ".reg_en"}, 32'(reg_en), 32'd1);
        chk({tag, ".reg_d"}, 32'(reg_d), 32'(ed));
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        chk({tag, ".ack"}, 32'(ack), 32'd1);
        chk({tag, ".en_off"}, 32'(reg_en), 32'd0);
        chk({tag, ".gnt_hold"}, 32'(gnt), 32'(egnt));
        ack_t = $time;
        req = req & ~drop;
        @(negedge clk);
        chk({tag, ".ack_pulse"}, 32'(ack), 32'd0);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst.gnt", 32'(gnt), 32'd0);
        chk("rst.ack", 32'(ack), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.reg_d", 32'(reg_d), 32'd0);
        chk("rst.reg_en", 32'(reg_en), 32'd0);
        chk("rst.stat", 32'(stat_cnt), 32'd0);
        rst_n = 1'b1;

        // Reset asserted in the middle of GRANT of requester 2
        @(negedge clk);
        req = 4'b0100;
        @(posedge clk);
        #1;
        chk("midrst.gnt_pre", 32'(gnt), 32'b0100);
        chk("midrst.en_pre", 32'(reg_en), 32'd1);
        chk("midrst.d_pre", 32'(reg_d), 32'hA);
        #2;
        rst_n = 1'b0;
        req = 4'b0000;
        #1;
        chk("midrst.gnt", 32'(gnt), 32'd0);
        chk("midrst.en", 32'(reg_en), 32'd0);
        chk("midrst.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst.no_ack", 32'(ack), 32'd0);
        // ptr back at 0: requester 0 beats requester 2
        req = 4'b0101;
        expect_write("ptr0", 4'b0001, 4'hC, 4'b0101);

        // Single write by requester 1
        req = 4'b0010;
        expect_write("single", 4'b0010, 4'h5, 4'b0010);
        chk("single.idle", 32'(busy), 32'd0);

        // Requester 3 moves ptr to 0, then all four request
        req = 4'b1000;
        expect_write("wrap3", 4'b1000, 4'h7, 4'b1000);
        req = 4'b1111;
        expect_write("rr0", 4'b0001, 4'hC, 4'b0001);
        t0 = ack_t;
        expect_write("rr1", 4'b0010, 4'h5, 4'b0010);
        chk("rr.spacing", 32'(ack_t - t0), 32'd30);
        expect_write("rr2", 4'b0100, 4'hA, 4'b0100);
        expect_write("rr3", 4'b1000, 4'h7, 4'b1000);

        // ptr to 1, then 1001 must go 3 then 0
        req = 4'b0001;
        expect_write("ptr1", 4'b0001, 4'hC, 4'b0001);
        req = 4'b1001;
        expect_write("rrb3", 4'b1000, 4'h7, 4'b1000);
        expect_write("rrb0", 4'b0001, 4'hC, 4'b0001);

        // Set has priority over a simultaneous write
        wdata = 16'h7A59;
        set_req = 1'b1;
        req = 4'b0001;
        @(negedge clk);
        chk("setp.reg_set", 32'(reg_set), 32'd1);
        chk("setp.gnt", 32'(gnt), 32'd0);
        chk("setp.busy", 32'(busy), 32'd1);
        chk("setp.en", 32'(reg_en), 32'd0);
        @(negedge clk);
        chk("setp.set_off", 32'(reg_set), 32'd0);
        chk("setp.set_ack", 32'(set_ack), 32'd1);
        set_req = 1'b0;
        @(negedge clk);
        chk("setp.ack_pulse", 32'(set_ack), 32'd0);
        expect_write("setp.w0", 4'b0001, 4'h9, 4'b0001);

        // set_req during GRANT of requester 2 waits for the write to finish
        req = 4'b0100;
        @(negedge clk);
        chk("guard.gnt", 32'(gnt), 32'b0100);
        set_req = 1'b1;
        @(negedge clk);
        chk("guard.ack", 32'(ack), 32'd1);
        chk("guard.no_set", 32'(reg_set), 32'd0);
        req = 4'b0000;
        @(negedge clk);
        chk("guard.idle_set", 32'(reg_set), 32'd0);
        @(negedge clk);
        chk("guard.reg_set", 32'(reg_set), 32'd1);
        @(negedge clk);
        chk("guard.set_ack", 32'(set_ack), 32'd1);
        set_req = 1'b0;
        @(negedge clk);
        chk("guard.busy", 32'(busy), 32'd0);

        // Write still commits when req drops during GRANT (ptr=3 -> winner 1)
        req = 4'b0010;
        @(negedge clk);
        chk("drop.gnt", 32'(gnt), 32'b0010);
        req = 4'b0000;
        @(negedge clk);
        chk("drop.ack", 32'(ack), 32'd1);
        @(negedge clk);

        // Statistics: fresh reset, then 300 back-to-back writes by requester 3
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1000;
        for (int k = 1; k <= 300; k++) begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (ack !== 1'b1 && n < 10);
            chk("stats.ack", 32'(ack), 32'd1);
            if (k == 5) begin
`ifdef ARB_STATS_EN
                chk("stats.cnt5", 32'(stat_cnt), 32'd5);
`else
                chk("stats.off5", 32'(stat_cnt), 32'd0);
`endif
            end
            if (k == 300) begin
                req = 4'b0000;
            end
        end
        @(negedge clk);
`ifdef ARB_STATS_EN
        chk("stats.sat", 32'(stat_cnt), 32'd255);
`else
        chk("stats.off", 32'(stat_cnt), 32'd0);
`endif
        stat_sel = 3'd0;
        #1;
        chk("stats.sel0", 32'(stat_cnt), 32'd0);
        stat_sel = 3'd7;
        #1;
        chk("stats.sel7", 32'(stat_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
